// File: rtl/ahb_sram_pkg.sv
// Shared AHB encodings and controller state for the AHB-to-SRAM bridge.
package ahb_sram_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {IDLE, WR, RDW, RD, ERR1, ERR2} state_t;

endpackage

// File: rtl/ahb_lane_decode.sv
// Byte-lane mask and size/alignment error for one AHB address phase.
module ahb_lane_decode #(
  parameter  int DATA_W = 32,
  localparam int BYTES  = DATA_W / 8,
  localparam int OFS    = $clog2(BYTES)
) (
  input  logic [2:0]       hsize,
  input  logic [OFS-1:0]   addr_lo,
  output logic [BYTES-1:0] lanes,
  output logic             err
);

  int nbytes;
  int lo;

  always_comb begin
    nbytes = 1 << hsize;
    lo     = int'(addr_lo);
    err    = (int'(hsize) > OFS) || ((lo & (nbytes - 1)) != 0);
    lanes  = '0;
    for (int i = 0; i < BYTES; i++) begin
      lanes[i] = !err && (i >= lo) && (i < lo + nbytes);
    end
  end

endmodule

// File: rtl/ahb_sram_if_p.sv
// AHB-Lite slave in front of a single-port synchronous SRAM, with a
// priority loader port that can steal the SRAM for whole cycles.
module ahb_sram_if_p
  import ahb_sram_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int RD_WAIT = 0
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic                  hsel,
  input  logic                  hreadyin,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [31:0]           haddr,
  input  logic [DATA_W-1:0]     hwdata,
  output logic [DATA_W-1:0]     hrdata,
  output logic                  hreadyout,
  output logic                  hresp,
  input  logic                  ld_en,
  input  logic [ADDR_W-1:0]     ld_addr,
  input  logic [DATA_W-1:0]     ld_data,
  output logic [DATA_W/8-1:0]   mem_wen,
  output logic                  mem_ren,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFS   = $clog2(BYTES);
  localparam logic [3:0] CNT_RD  = 4'(RD_WAIT);
  localparam logic [3:0] CNT_COL = 4'(RD_WAIT + 1);

  state_t              state;
  logic [3:0]          cnt;
  logic [ADDR_W-1:0]   addr_p1;
  logic [BYTES-1:0]    lanes_p1;
  logic [DATA_W-1:0]   rd_buf;
  logic                rd_buf_vld;

  logic [ADDR_W-1:0]   haddr_word;
  logic [BYTES-1:0]    dec_lanes;
  logic                dec_err;
  logic                ld_act;
  logic                acc;
  logic                unused_bits;

  assign haddr_word  = haddr[ADDR_W+OFS-1:OFS];
  assign unused_bits = ^{haddr[31:ADDR_W+OFS], htrans[0]};

  ahb_lane_decode #(.DATA_W(DATA_W)) u_lane_decode (
    .hsize   (hsize),
    .addr_lo (haddr[OFS-1:0]),
    .lanes   (dec_lanes),
    .err     (dec_err)
  );

  // Loader strobes are masked by reset so the SRAM sees nothing while hreset is high.
  assign ld_act = ld_en & ~hreset;

  always_comb begin
    case (state)
      IDLE, WR, RD, ERR2: hreadyout = ~ld_act;
      default:            hreadyout = 1'b0;
    endcase
  end

  assign acc   = hsel & hreadyin & htrans[1] & hreadyout & ~hreset;
  assign hresp = (state == ERR1 || state == ERR2) ? HRESP_ERROR : HRESP_OKAY;

  always_comb begin
    hrdata = '0;
    if (state == RD && !ld_act) hrdata = rd_buf_vld ? rd_buf : mem_rdata;
  end

  // Read strobe goes out one cycle before the data phase completes; a read
  // arriving while WR owns the port is pushed into RDW instead.
  always_comb begin
    mem_ren = 1'b0;
    if (state == RDW && cnt == 4'd1 && !ld_act) mem_ren = 1'b1;
    else if (acc && !hwrite && !dec_err && RD_WAIT == 0 && state != WR) mem_ren = 1'b1;
  end

  always_comb begin
    mem_wen   = '0;
    mem_addr  = haddr_word;
    mem_wdata = hwdata;
    if (ld_act) begin
      mem_wen   = '1;
      mem_addr  = ld_addr;
      mem_wdata = ld_data;
    end else if (state == WR) begin
      mem_wen  = lanes_p1;
      mem_addr = addr_p1;
    end else if (state == RDW) begin
      mem_addr = addr_p1;
    end
  end

  // Address phase -> data phase
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state      <= IDLE;
      cnt        <= '0;
      addr_p1    <= '0;
      lanes_p1   <= '0;
      rd_buf_vld <= 1'b0;
    end else if (ld_en) begin
      if (state == RD) rd_buf_vld <= 1'b1;
    end else begin
      rd_buf_vld <= 1'b0;
      if (acc) begin
        addr_p1  <= haddr_word;
        lanes_p1 <= dec_lanes;
        if (dec_err) begin
          state <= ERR1;
        end else if (hwrite) begin
          state <= WR;
        end else if (state == WR) begin
          cnt   <= CNT_COL;
          state <= RDW;
        end else if (RD_WAIT == 0) begin
          state <= RD;
        end else begin
          cnt   <= CNT_RD;
          state <= RDW;
        end
      end else begin
        case (state)
          RDW: begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) state <= RD;
          end
          ERR1:    state <= ERR2;
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Read data held across a loader stall of the RD cycle
  always_ff @(posedge hclk) begin
    if (ld_en && state == RD && !rd_buf_vld) rd_buf <= mem_rdata;
  end

endmodule

// File: tb/tb_ahb_sram_if_p.sv
// Bench for ahb_sram_if_p: RD_WAIT=0 and RD_WAIT=3 instances, each with its own SRAM model.
module tb_ahb_sram_if_p;
  import ahb_sram_pkg::*;

  localparam int AW = 8;

  logic hclk = 1'b0;
  always #5 hclk = ~hclk;

  logic hreset, mem_clr, hsel_a, hsel_b, hreadyin, hwrite, ld_en;
  logic [1:0] htrans;
  logic [2:0] hsize;
  logic [31:0] haddr, hwdata, ld_data;
  logic [AW-1:0] ld_addr;

  logic [31:0] hrdata_a, hrdata_b, mem_wdata_a, mem_wdata_b, mem_rdata_a, mem_rdata_b;
  logic hreadyout_a, hreadyout_b, hresp_a, hresp_b, mem_ren_a, mem_ren_b;
  logic [3:0] mem_wen_a, mem_wen_b;
  logic [AW-1:0] mem_addr_a, mem_addr_b;

  ahb_sram_if_p #(.ADDR_W(AW), .DATA_W(32), .RD_WAIT(0)) dut_a (
    .hclk(hclk), .hreset(hreset), .hsel(hsel_a), .hreadyin(hreadyin), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .haddr(haddr), .hwdata(hwdata), .hrdata(hrdata_a),
    .hreadyout(hreadyout_a), .hresp(hresp_a), .ld_en(ld_en), .ld_addr(ld_addr),
    .ld_data(ld_data), .mem_wen(mem_wen_a), .mem_ren(mem_ren_a), .mem_addr(mem_addr_a),
    .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a));

  ahb_sram_if_p #(.ADDR_W(AW), .DATA_W(32), .RD_WAIT(3)) dut_b (
    .hclk(hclk), .hreset(hreset), .hsel(hsel_b), .hreadyin(hreadyin), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .haddr(haddr), .hwdata(hwdata), .hrdata(hrdata_b),
    .hreadyout(hreadyout_b), .hresp(hresp_b), .ld_en(ld_en), .ld_addr(ld_addr),
    .ld_data(ld_data), .mem_wen(mem_wen_b), .mem_ren(mem_ren_b), .mem_addr(mem_addr_b),
    .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b));

  // Synchronous SRAM models
  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];

  always @(posedge hclk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) begin
        mem_a[i] <= '0;
        mem_b[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (mem_wen_a[i]) mem_a[mem_addr_a][8*i +: 8] <= mem_wdata_a[8*i +: 8];
        if (mem_wen_b[i]) mem_b[mem_addr_b][8*i +: 8] <= mem_wdata_b[8*i +: 8];
      end
      if (mem_ren_a) mem_rdata_a <= mem_a[mem_addr_a];
      if (mem_ren_b) mem_rdata_b <= mem_b[mem_addr_b];
    end
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge hclk) begin
    if (!hreset) begin
      n_cmp++;
      if ((|mem_wen_a && mem_ren_a) || (|mem_wen_b && mem_ren_b) ||
          (!hreadyout_a && hrdata_a != 0) || (!hreadyout_b && hrdata_b != 0)) begin
        n_fail++;
        $display("FAIL invariant: wen_a=%h ren_a=%b rdy_a=%b rdata_a=%h wen_b=%h ren_b=%b rdy_b=%b rdata_b=%h",
                 mem_wen_a, mem_ren_a, hreadyout_a, hrdata_a, mem_wen_b, mem_ren_b, hreadyout_b, hrdata_b);
      end
    end
  end

  typedef struct {
    logic        wr;
    logic [2:0]  sz;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  exp_wen;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic        rd;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];

  // One non-pipelined transfer on instance A: address phase, then data phase until hreadyout.
  task automatic run_vec(input vec_t v, input string nm);
    exp_t e;
    int waits;
    @(posedge hclk); #1;
    hsel_a = 1'b1; htrans = HTRANS_NONSEQ; hwrite = v.wr; hsize = v.sz; haddr = v.addr;
    e.rd = !v.wr; e.err = v.exp_err; e.rdata = v.exp_rdata;
    sb.push_back(e);
    @(negedge hclk);
    check({nm, "/ren_addr_phase"}, mem_ren_a, !v.wr && !v.exp_err);
    if (!v.wr && !v.exp_err) check({nm, "/raddr"}, mem_addr_a, v.addr[9:2]);
    @(posedge hclk); #1;
    hsel_a = 1'b0; htrans = HTRANS_IDLE; hwdata = v.wdata;
    @(negedge hclk);
    check({nm, "/wen"}, mem_wen_a, v.exp_wen);
    if (v.wr && !v.exp_err) check({nm, "/waddr"}, mem_addr_a, v.addr[9:2]);
    waits = 0;
    while (!hreadyout_a && waits < 8) begin
      check({nm, "/hresp_wait"}, hresp_a, v.exp_err);
      waits++;
      @(negedge hclk);
    end
    e = sb.pop_front();
    check({nm, "/waits"}, waits, e.err ? 1 : 0);
    check({nm, "/hresp"}, hresp_a, e.err);
    if (e.err) check({nm, "/hrdata_err"}, hrdata_a, 32'h0);
    else if (e.rd) check({nm, "/hrdata"}, hrdata_a, e.rdata);
  endtask

  localparam int NV = 13;
  vec_t vecs[NV];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int waits, ren_at, ren_cnt;
    logic [AW-1:0] ren_addr;

    hreset = 1'b1; mem_clr = 1'b1; hsel_a = 0; hsel_b = 0; hreadyin = 1'b1;
    htrans = HTRANS_IDLE; hwrite = 0; hsize = HSIZE_WORD; haddr = 0; hwdata = 0;
    ld_en = 0; ld_addr = 0; ld_data = 0;
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    check("rst/hreadyout", hreadyout_a, 1'b1);
    check("rst/hresp", hresp_a, 1'b0);
    check("rst/mem_wen", mem_wen_a, 4'h0);
    check("rst/mem_ren", mem_ren_a, 1'b0);
    check("rst/hrdata", hrdata_a, 32'h0);
    check("rst/hreadyout_b", hreadyout_b, 1'b1);
    hreset = 1'b0; mem_clr = 1'b0;

    vecs[0]  = '{1'b1, HSIZE_WORD,  32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, HSIZE_WORD,  32'h10, 32'h0,        4'h0, 1'b0, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, HSIZE_BYTE,  32'h13, 32'hAA000000, 4'h8, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, HSIZE_WORD,  32'h10, 32'h0,        4'h0, 1'b0, 32'hAAADBEEF};
    vecs[4]  = '{1'b1, HSIZE_HALF,  32'h22, 32'h12340000, 4'hC, 1'b0, 32'h0};
    vecs[5]  = '{1'b0, HSIZE_BYTE,  32'h23, 32'h0,        4'h0, 1'b0, 32'h12340000};
    vecs[6]  = '{1'b1, HSIZE_HALF,  32'h01, 32'hFFFFFFFF, 4'h0, 1'b1, 32'h0};
    vecs[7]  = '{1'b0, HSIZE_DWORD, 32'h00, 32'h0,        4'h0, 1'b1, 32'h0};
    vecs[8]  = '{1'b0, HSIZE_WORD,  32'h02, 32'h0,        4'h0, 1'b1, 32'h0};
    vecs[9]  = '{1'b1, HSIZE_HALF,  32'h30, 32'h00005555, 4'h3, 1'b0, 32'h0};
    vecs[10] = '{1'b0, HSIZE_HALF,  32'h32, 32'h0,        4'h0, 1'b0, 32'h00005555};
    vecs[11] = '{1'b1, HSIZE_BYTE,  32'h31, 32'h0000BB00, 4'h2, 1'b0, 32'h0};
    vecs[12] = '{1'b0, HSIZE_WORD,  32'h30, 32'h0,        4'h0, 1'b0, 32'h0000BB55};
    for (int i = 0; i < NV; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Pipelined write then read to the same word: the read collides with WR.
    @(posedge hclk); #1;
    hsel_a = 1; htrans = HTRANS_NONSEQ; hwrite = 1; hsize = HSIZE_WORD; haddr = 32'h10;
    @(posedge hclk); #1;
    hwdata = 32'hDEADBEEF; hwrite = 0;
    @(negedge hclk);
    check("col/wen", mem_wen_a, 4'hF);
    check("col/waddr", mem_addr_a, 8'd4);
    check("col/wr_ready", hreadyout_a, 1'b1);
    check("col/no_early_ren", mem_ren_a, 1'b0);
    @(posedge hclk); #1;
    hsel_a = 0; htrans = HTRANS_IDLE;
    @(negedge hclk);
    check("col/wait", hreadyout_a, 1'b0);
    check("col/ren", mem_ren_a, 1'b1);
    check("col/raddr", mem_addr_a, 8'd4);
    @(negedge hclk);
    check("col/rd_ready", hreadyout_a, 1'b1);
    check("col/hrdata", hrdata_a, 32'hDEADBEEF);

    // Loader write while both slaves are idle.
    @(posedge hclk); #1;
    ld_en = 1; ld_addr = 8'd8; ld_data = 32'hCAFEF00D;
    @(negedge hclk);
    check("ld/idle_ready", hreadyout_a, 1'b0);
    check("ld/wen", mem_wen_a, 4'hF);
    check("ld/addr", mem_addr_a, 8'd8);
    check("ld/wdata", mem_wdata_a, 32'hCAFEF00D);
    @(posedge hclk); #1;
    ld_en = 0;
    run_vec('{1'b0, HSIZE_WORD, 32'h20, 32'h0, 4'h0, 1'b0, 32'hCAFEF00D}, "ld_rd");

    // Loader held two cycles over a WR data phase to the same word.
    @(posedge hclk); #1;
    hsel_a = 1; htrans = HTRANS_NONSEQ; hwrite = 1; hsize = HSIZE_WORD; haddr = 32'h50;
    @(posedge hclk); #1;
    hsel_a = 0; htrans = HTRANS_IDLE; hwdata = 32'h11112222;
    ld_en = 1; ld_addr = 8'd20; ld_data = 32'h33334444;
    @(negedge hclk);
    check("ldwr/c1_ready", hreadyout_a, 1'b0);
    check("ldwr/c1_wdata", mem_wdata_a, 32'h33334444);
    check("ldwr/c1_wen", mem_wen_a, 4'hF);
    @(negedge hclk);
    check("ldwr/c2_ready", hreadyout_a, 1'b0);
    check("ldwr/c2_wdata", mem_wdata_a, 32'h33334444);
    @(posedge hclk); #1;
    ld_en = 0;
    @(negedge hclk);
    check("ldwr/c3_ready", hreadyout_a, 1'b1);
    check("ldwr/c3_wen", mem_wen_a, 4'hF);
    check("ldwr/c3_addr", mem_addr_a, 8'd20);
    check("ldwr/c3_wdata", mem_wdata_a, 32'h11112222);
    run_vec('{1'b0, HSIZE_WORD, 32'h50, 32'h0, 4'h0, 1'b0, 32'h11112222}, "ldwr_rd");

    // RD_WAIT=3 read on instance B.
    @(posedge hclk); #1;
    hsel_b = 1; htrans = HTRANS_NONSEQ; hwrite = 0; hsize = HSIZE_WORD; haddr = 32'h20;
    @(negedge hclk);
    check("w3/no_addr_phase_ren", mem_ren_b, 1'b0);
    @(posedge hclk); #1;
    hsel_b = 0; htrans = HTRANS_IDLE;
    waits = 0; ren_at = 0; ren_addr = '0;
    @(negedge hclk);
    while (!hreadyout_b && waits < 10) begin
      waits++;
      if (mem_ren_b) begin
        ren_at = waits;
        ren_addr = mem_addr_b;
      end
      @(negedge hclk);
    end
    check("w3/waits", waits, 3);
    check("w3/ren_cycle", ren_at, 3);
    check("w3/ren_addr", ren_addr, 8'd8);
    check("w3/hrdata", hrdata_b, 32'hCAFEF00D);

    // Reset asserted during RDW on instance B.
    @(posedge hclk); #1;
    hsel_b = 1; htrans = HTRANS_NONSEQ; hwrite = 0; hsize = HSIZE_WORD; haddr = 32'h24;
    @(posedge hclk); #1;
    hsel_b = 0; htrans = HTRANS_IDLE;
    #2 hreset = 1'b1;
    #1;
    check("rstw/hreadyout", hreadyout_b, 1'b1);
    check("rstw/hresp", hresp_b, 1'b0);
    check("rstw/mem_ren", mem_ren_b, 1'b0);
    check("rstw/mem_wen", mem_wen_b, 4'h0);
    check("rstw/hrdata", hrdata_b, 32'h0);
    ren_cnt = 0;
    repeat (2) begin
      @(negedge hclk);
      if (mem_ren_b) ren_cnt++;
    end
    hreset = 1'b0;
    repeat (4) begin
      @(negedge hclk);
      if (mem_ren_b) ren_cnt++;
    end
    check("rstw/no_ren_after", ren_cnt, 0);
    check("rstw/idle_ready", hreadyout_b, 1'b1);
    run_vec('{1'b0, HSIZE_WORD, 32'h10, 32'h0, 4'h0, 1'b0, 32'hDEADBEEF}, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
